// File: rtl/seq_tx.sv
// seq_tx: serial frame transmitter feeding a `1101` sequence detector.
// A payload word is accepted over valid/ready. The 4-bit sync preamble 1101
// goes out first, then the payload MSB-first, one bit per clock. The line
// idles at 0 between frames.
// Optional feature: define SEQ_TX_PARITY_EN to append an even-parity bit
// (XOR of the payload) after the last payload bit.
module seq_tx #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 o,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_SYNC_LAST = CW'(3);
  localparam logic [CW-1:0] CNT_DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] CNT_DATA_PRE  = CW'(DATA_BITS - 2);

`ifdef SEQ_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, DATA = 2'd2, PAR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, DATA = 2'd2} state_t;
`endif

  state_t                 state_r;
  logic [CW-1:0]          cnt_r;
  logic [DATA_BITS-1:0]   sh_r;
  logic                   o_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   ready_s;
  logic                   accept_s;
`ifdef SEQ_TX_PARITY_EN
  logic                   par_r;

  // Even parity over the payload word.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`endif

  // Sync bit that follows preamble position idx (preamble is 1,1,0,1).
  function automatic logic sync_next(input logic [CW-1:0] idx);
    logic b;
    case (idx)
      CW'(0):  b = 1'b1;
      CW'(1):  b = 1'b0;
      CW'(2):  b = 1'b1;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  // Ready when idle or while the final frame bit is on the line (done_r marks it).
  always_comb begin
    ready_s = 1'b0;
    if (rst) begin
      ready_s = 1'b0;
    end else if ((state_r == IDLE) || done_r) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  assign accept_s = tx_valid && ready_s;
  assign tx_ready = ready_s;
  assign o        = o_r;
  assign busy     = busy_r;
  assign done     = done_r;

  // Frame FSM: registers the bit to be shown on the line in the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      sh_r    <= '0;
      o_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else if (accept_s) begin
      // Start a frame, from IDLE or back-to-back from the final bit.
      state_r <= SYNC;
      cnt_r   <= '0;
      sh_r    <= tx_data;
      o_r     <= 1'b1;
      busy_r  <= 1'b1;
      done_r  <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      par_r   <= parity_of(tx_data);
`endif
    end else if (done_r) begin
      // Final bit shown and nothing queued: release the line.
      state_r <= IDLE;
      cnt_r   <= '0;
      o_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          o_r    <= 1'b0;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
        SYNC: begin
          if (cnt_r == CNT_SYNC_LAST) begin
            state_r <= DATA;
            cnt_r   <= '0;
            o_r     <= sh_r[DATA_BITS-1];
            done_r  <= 1'b0;
          end else begin
            cnt_r   <= cnt_r + CW'(1);
            o_r     <= sync_next(cnt_r);
          end
        end
        DATA: begin
          if (cnt_r == CNT_DATA_LAST) begin
`ifdef SEQ_TX_PARITY_EN
            state_r <= PAR;
            cnt_r   <= '0;
            o_r     <= par_r;
            done_r  <= 1'b1;
`else
            // Last payload bit is the frame end; handled by the done_r path.
            state_r <= IDLE;
            cnt_r   <= '0;
            o_r     <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`endif
          end else begin
            cnt_r <= cnt_r + CW'(1);
            o_r   <= sh_r[DATA_BITS-2];
            sh_r  <= {sh_r[DATA_BITS-2:0], 1'b0};
`ifdef SEQ_TX_PARITY_EN
            done_r <= 1'b0;
`else
            done_r <= (cnt_r == CNT_DATA_PRE);
`endif
          end
        end
`ifdef SEQ_TX_PARITY_EN
        PAR: begin
          // Parity cycle is always final; handled by the done_r path.
          state_r <= IDLE;
          cnt_r   <= '0;
          o_r     <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
`endif
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          o_r     <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_tx.sv
// Directed self-checking bench for seq_tx (DATA_BITS=8).
module tb_seq_tx;

`ifdef SEQ_TX_PARITY_EN
  localparam int L = 13;
`else
  localparam int L = 12;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       o;
  logic       busy;
  logic       done;

  int         n_checks;
  int         n_bad;
  logic [2:0] hist;

  seq_tx #(.DATA_BITS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .o        (o),
    .busy     (busy),
    .done     (done)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected line bit n of a frame: 12 hand-written sync+payload bits, then parity.
  function automatic logic exp_bit(input logic [11:0] bits, input logic par, input int n);
    if (n < 12) return bits[11 - n];
    return par;
  endfunction

  // Checks one full frame; called at the negedge of its first bit cycle.
  task automatic frame_check(input string tag, input logic [11:0] bits, input logic par,
                             input logic drop_valid, input logic [7:0] next_data,
                             input logic det);
    logic m;
    if (det) hist = 3'b000;
    for (int n = 0; n < L; n++) begin
      check($sformatf("%s.o[%0d]", tag, n), o, exp_bit(bits, par, n));
      check($sformatf("%s.busy[%0d]", tag, n), busy, 1'b1);
      check($sformatf("%s.done[%0d]", tag, n), done, (n == L - 1));
      check($sformatf("%s.rdy[%0d]", tag, n), tx_ready, (n == L - 1));
      if (det) begin
        m = (hist == 3'b110) && o;
        hist = {hist[1:0], o};
        check($sformatf("%s.det[%0d]", tag, n), m, (n == 3));
      end
      if (n == 0) begin
        tx_data = next_data;
        if (drop_valid) tx_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_bad    = 0;
    hist     = 3'b000;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    // Reset: outputs low and not ready while asserted.
    @(negedge clk);
    @(negedge clk);
    check("rst.o", o, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.rdy", tx_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("rst.rdy_after", tx_ready, 1'b1);

    // Idle 5 cycles with no request.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("idle.o[%0d]", i), o, 1'b0);
      check($sformatf("idle.busy[%0d]", i), busy, 1'b0);
      check($sformatf("idle.done[%0d]", i), done, 1'b0);
      check($sformatf("idle.rdy[%0d]", i), tx_ready, 1'b1);
    end

    // Single frame 8'hA5, then line returns to idle.
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    frame_check("a5", 12'b1101_1010_0101, 1'b0, 1'b1, 8'h5A, 1'b0);
    check("a5.o_after", o, 1'b0);
    check("a5.busy_after", busy, 1'b0);
    check("a5.rdy_after", tx_ready, 1'b1);
    @(negedge clk);

    // Back-to-back: 8'h3C then 8'hFF with valid held.
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(negedge clk);
    frame_check("b2b1", 12'b1101_0011_1100, 1'b0, 1'b0, 8'hFF, 1'b0);
    frame_check("b2b2", 12'b1101_1111_1111, 1'b0, 1'b1, 8'h11, 1'b0);
    check("b2b.busy_after", busy, 1'b0);
    check("b2b.o_after", o, 1'b0);
    @(negedge clk);

    // Abort 8'h81 with reset at bit 6.
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    @(negedge clk);
    for (int n = 0; n <= 6; n++) begin
      check($sformatf("abort.o[%0d]", n), o, exp_bit(12'b1101_1000_0001, 1'b0, n));
      if (n == 0) tx_valid = 1'b0;
      if (n == 6) rst = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    check("abort.o", o, 1'b0);
    check("abort.busy", busy, 1'b0);
    check("abort.done", done, 1'b0);
    check("abort.rdy", tx_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("abort.rdy_after", tx_ready, 1'b1);

    // Frame 8'h00 after the abort, looped into a Mealy 1101 detector model.
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    frame_check("zero", 12'b1101_0000_0000, 1'b0, 1'b1, 8'h00, 1'b1);
    check("zero.busy_after", busy, 1'b0);

`ifdef SEQ_TX_PARITY_EN
    // Parity frame 8'h07: payload has three ones, parity bit 1.
    @(negedge clk);
    tx_data  = 8'h07;
    tx_valid = 1'b1;
    @(negedge clk);
    frame_check("par", 12'b1101_0000_0111, 1'b1, 1'b1, 8'h00, 1'b0);
    check("par.busy_after", busy, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_tx.md
# seq_tx

Serial frame transmitter that drives the single-bit input of the `1101` sequence-detector FSM. It accepts a parallel payload word over a valid/ready handshake. It then shifts out, one bit per clock, the 4-bit sync preamble `1101` followed by the payload MSB-first. Between frames the line idles at 0, so the downstream detector sees exactly one sync match per frame preamble. It sits between a word-level producer and the serial link.

## Interface
- `DATA_BITS`, 8, payload width in bits; legal range 2..32.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `tx_data`  in  DATA_BITS  payload word; sampled only on an accepted transfer.
- `tx_valid`  in  1  producer has a word on `tx_data`.
- `tx_ready`  out  1  transmitter can accept a word this cycle.
- `o`  out  1  serial line to the detector input; registered.
- `busy`  out  1  a frame bit is on `o` this cycle; registered.
- `done`  out  1  one-cycle pulse coincident with the final frame bit on `o`; registered.

## Operation
- States:
  - IDLE: `o`=0, `busy`=0.
  - SYNC: 4 cycles, emits 1,1,0,1.
  - DATA: DATA_BITS cycles, emits `tx_data[DATA_BITS-1]` first, down to `[0]`.
  - PAR: 1 cycle, exists only when the macro below is defined.
- Transfer accepted on an edge where `tx_valid && tx_ready`. `tx_data` is captured into an internal shift register on that edge.
- `tx_ready` = 1 in IDLE, and also 1 during the final bit cycle of a frame. It is 0 in all other cycles and 0 while `rst`=1.
- Transitions:
  - IDLE → SYNC on accept.
  - SYNC → DATA after the 4th sync bit.
  - DATA → PAR (or the frame end) after bit 0.
  - Frame end → SYNC if a transfer is accepted in the final bit cycle (back-to-back frames, no idle gap); otherwise → IDLE.
- Frame length L = 4 + DATA_BITS (+1 with parity).
- Bit counter width is clog2(DATA_BITS+1). It resets to 0 on entry to each phase and never wraps within a phase.
- `tx_data` changes while not accepted are ignored. A `tx_valid` deassert mid-frame has no effect.
- `rst` mid-frame: the frame is abandoned. On the next edge `o`=0, `busy`=0, `done`=0, state = IDLE. No partial bits resume.

## Timing
- Reset values: `o`=0, `busy`=0, `done`=0, `tx_ready`=0 while asserted. `tx_ready`=1 in the first cycle after `rst` drops.
- Latency: accept at edge k gives first sync bit `o`=1 and `busy`=1 in cycle k+1 (after edge k).
- Frame bit n (0-based) is on `o` during cycle k+1+n. The final bit is at n = L-1; `done`=1 in that cycle only.
- Back-to-back: accept in the final bit cycle; the next frame's first sync bit follows with zero idle cycles.
- Without back-to-back, `o` returns to 0 and `busy` to 0 in cycle k+1+L.
- Detector alignment: a Mealy `1101` detector fed by `o` asserts during bit n=3 of every frame. Payload bits may cause additional matches; that is the detector's concern, not this block's.

## Configuration
- `SEQ_TX_PARITY_EN` defined: a PAR bit is appended after DATA. It equals the XOR of all payload bits (even parity over the payload). L = 5 + DATA_BITS, and `done`/`tx_ready` move to the PAR cycle.
- `SEQ_TX_PARITY_EN` undefined: no PAR state or logic. L = 4 + DATA_BITS, and the final bit is payload bit 0.

## Test plan
All scenarios use DATA_BITS=8 and no parity unless stated.
- Reset then idle 5 cycles, `tx_valid`=0 → `o`=0, `busy`=0, `done`=0, `tx_ready`=1 throughout.
- Send 8'hA5 → `o` sequence over 12 cycles = 1,1,0,1,1,0,1,0,0,1,0,1.
  - `busy`=1 for those 12 cycles; `done`=1 only on the 12th; `o`=0 after.
- Send 8'h3C, then present 8'hFF with `tx_valid` held → second accept occurs in frame 1's 12th cycle.
  - 24 contiguous `busy` cycles; frame 2 bits = 1,1,0,1 then eight 1s.
- Assert `rst` for 1 cycle at bit 6 of a frame carrying 8'h81 → `o`=0, `busy`=0 the next cycle.
  - A following 8'h00 frame transmits intact: 1,1,0,1 then eight 0s.
- Loopback to a Mealy `1101` detector, sending 8'h00 → detector output=1 exactly once, in cycle k+4 (bit 3).
- With `SEQ_TX_PARITY_EN`, send 8'h07 → 13 bits: 1,1,0,1,0,0,0,0,0,1,1,1 then parity 1.
  - `done` on bit 13.
